fifo_mac_drain: RTL and testbench



---
 rtl/npu_pkg.sv | 17 +
 rtl/fifo_mac_datapath.sv | 84 ++++++++
 rtl/fifo_mac_drain.sv | 114 +++++++++++
 tb/tb_fifo_mac_drain.sv | 396 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/npu_pkg.sv
// Purpose : shared NPU datapath types and default sizing constants.
// Latency : n/a (package only).
// Backpressure : n/a (package only).
package npu_pkg;

    // Drain FSM states shared by FIFO-consuming MAC blocks.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mac_state_t;

    localparam int NBITS_DEF   = 16;
    localparam int MAX_LEN_DEF = 64;
    localparam int FRAC_DEF    = 8;

endpackage : npu_pkg

// File: rtl/fifo_mac_datapath.sv
// Purpose : signed multiply, accumulate and quantize for the FIFO drain MAC.
// Latency : acc_o and data_o are registered one edge after clr_i/en_i.
// Backpressure : none; the parent FSM gates en_i.
//
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   clr_i              zero the accumulator on the next edge (wins over en_i)
//   en_i               add a_i*w_i into the accumulator on the next edge
//   a_i, w_i           signed operands
//   acc_o              raw accumulator
//   data_o             quantized accumulator (acc >>> FRAC)
// Build option: FIFO_MAC_SAT_EN selects clamping instead of wrapping for data_o.
module fifo_mac_datapath #(
    parameter int NBITS    = 16,
    parameter int ACC_BITS = 38,
    parameter int FRAC     = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       clr_i,
    input  logic                       en_i,
    input  logic signed [NBITS-1:0]    a_i,
    input  logic signed [NBITS-1:0]    w_i,
    output logic        [ACC_BITS-1:0] acc_o,
    output logic        [NBITS-1:0]    data_o
);

    logic signed [2*NBITS-1:0]  prod;
    logic signed [ACC_BITS-1:0] acc_q, acc_d;
    logic        [NBITS-1:0]    data_q, data_d;

    assign prod = a_i * w_i;

    always_comb begin
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (en_i) begin
            acc_d = acc_q + {{(ACC_BITS-2*NBITS){prod[2*NBITS-1]}}, prod};
        end
    end

    // The quantized output is computed from the next accumulator value so
    // that it lands in a register on the same edge as the accumulator; in
    // DONE the accumulator holds, so data_q stays consistent with acc_q.
`ifdef FIFO_MAC_SAT_EN
    localparam logic signed [ACC_BITS-1:0] SAT_MAX =
        {{(ACC_BITS-NBITS+1){1'b0}}, {(NBITS-1){1'b1}}};
    localparam logic signed [ACC_BITS-1:0] SAT_MIN =
        {{(ACC_BITS-NBITS+1){1'b1}}, {(NBITS-1){1'b0}}};

    logic signed [ACC_BITS-1:0] shifted;

    always_comb begin
        shifted = acc_d >>> FRAC;
        if (shifted > SAT_MAX) begin
            data_d = SAT_MAX[NBITS-1:0];
        end else if (shifted < SAT_MIN) begin
            data_d = SAT_MIN[NBITS-1:0];
        end else begin
            data_d = shifted[NBITS-1:0];
        end
    end
`else
    // Wrapping: the low NBITS bits of acc >>> FRAC are just a slice of acc.
    always_comb begin
        data_d = acc_d[FRAC +: NBITS];
    end
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q  <= '0;
            data_q <= '0;
        end else begin
            acc_q  <= acc_d;
            data_q <= data_d;
        end
    end

    assign acc_o  = acc_q;
    assign data_o = data_q;

endmodule : fifo_mac_datapath

// File: rtl/fifo_mac_drain.sv
// Purpose : pops paired activation/weight FIFOs, accumulates len products, presents quantized dot product.
// Latency : out_valid len+1 cycles after start at full rate (1 cycle for len=0); one element per cycle.
// Backpressure : FIFO empties stall RUN indefinitely; out_ready low holds the result in DONE.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   start, len, busy         command (honoured only in IDLE) and status
//   a_empty, a_q, a_ren      activation FIFO (combinational-read pop)
//   w_empty, w_q, w_ren      weight FIFO (combinational-read pop)
//   out_valid, out_ready     result handshake
//   out_data, out_acc        quantized and raw result, registered
// Build option: FIFO_MAC_SAT_EN clamps out_data instead of wrapping.
module fifo_mac_drain
    import npu_pkg::*;
#(
    parameter int NBITS    = NBITS_DEF,
    parameter int MAX_LEN  = MAX_LEN_DEF,
    parameter int LEN_W    = $clog2(MAX_LEN) + 1,
    parameter int ACC_BITS = 2*NBITS + $clog2(MAX_LEN),
    parameter int FRAC     = FRAC_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic        [LEN_W-1:0]    len,
    output logic                       busy,
    input  logic                       a_empty,
    input  logic signed [NBITS-1:0]    a_q,
    output logic                       a_ren,
    input  logic                       w_empty,
    input  logic signed [NBITS-1:0]    w_q,
    output logic                       w_ren,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic        [NBITS-1:0]    out_data,
    output logic        [ACC_BITS-1:0] out_acc
);

    mac_state_t       state_q, state_d;
    logic [LEN_W-1:0] count_q, count_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] count_inc;
    logic             pop;
    logic             clr;

    // Both FIFOs pop together or not at all, so operands stay paired.
    assign pop       = (state_q == RUN) & ~a_empty & ~w_empty;
    assign a_ren     = pop;
    assign w_ren     = pop;
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == DONE);
    assign count_inc = count_q + LEN_W'(1);

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        len_d   = len_q;
        clr     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    clr     = 1'b1;
                    count_d = '0;
                    len_d   = len;
                    state_d = (len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (pop) begin
                    count_d = count_inc;
                    if (count_inc == len_q) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            count_q <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            len_q   <= len_d;
        end
    end

    fifo_mac_datapath #(
        .NBITS    (NBITS),
        .ACC_BITS (ACC_BITS),
        .FRAC     (FRAC)
    ) u_datapath (
        .clk_i  (clk),
        .rst_ni (rst),
        .clr_i  (clr),
        .en_i   (pop),
        .a_i    (a_q),
        .w_i    (w_q),
        .acc_o  (out_acc),
        .data_o (out_data)
    );

endmodule : fifo_mac_drain

// File: tb/tb_fifo_mac_drain.sv
// Purpose : self-checking bench for fifo_mac_drain with queue-modelled FIFOs.
// Latency : n/a.
// Backpressure : bench drives FIFO stalls and out_ready patterns.
module tb_fifo_mac_drain;

    localparam int NBITS    = 16;
    localparam int MAX_LEN  = 64;
    localparam int LEN_W    = 7;
    localparam int ACC_BITS = 38;
    localparam int FRAC     = 8;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic [LEN_W-1:0]    len;
    logic                busy;
    logic                a_empty, w_empty;
    logic [NBITS-1:0]    a_q, w_q;
    logic                a_ren, w_ren;
    logic                out_valid;
    logic                out_ready;
    logic [NBITS-1:0]    out_data;
    logic [ACC_BITS-1:0] out_acc;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;
    int pop_cnt      = 0;
    int ren_mismatch = 0;
    int underflow    = 0;
    bit a_block      = 1'b0;
    bit w_block      = 1'b0;
    bit rnd_stall    = 1'b0;

    logic [NBITS-1:0] aq[$];
    logic [NBITS-1:0] wq[$];

    always #5 clk = ~clk;

    fifo_mac_drain #(
        .NBITS(NBITS), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W),
        .ACC_BITS(ACC_BITS), .FRAC(FRAC)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy),
        .a_empty(a_empty), .a_q(a_q), .a_ren(a_ren),
        .w_empty(w_empty), .w_q(w_q), .w_ren(w_ren),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_acc(out_acc)
    );

    // FIFO model: pops on the edge where ren is seen high.
    always @(posedge clk) begin
        cyc++;
        if (a_ren !== w_ren) ren_mismatch++;
        if (a_ren === 1'b1) begin
            if (aq.size() == 0) underflow++;
            else void'(aq.pop_front());
            pop_cnt++;
        end
        if (w_ren === 1'b1) begin
            if (wq.size() == 0) underflow++;
            else void'(wq.pop_front());
        end
    end

    // FIFO outputs refresh mid-cycle so they are stable at the next edge.
    always @(negedge clk) begin
        #1;
        if (rnd_stall) begin
            a_block = ($urandom_range(0, 3) == 0);
            w_block = ($urandom_range(0, 3) == 0);
        end
        a_empty = (aq.size() == 0) || a_block;
        w_empty = (wq.size() == 0) || w_block;
        a_q     = (aq.size() != 0) ? aq[0] : '0;
        w_q     = (wq.size() != 0) ? wq[0] : '0;
    end

    // Reference: dot product of the first n pairs, floor-shifted, then wrapped or clamped.
    function automatic void ref_model(input int av[$], input int wv[$], input int n,
                                      output logic [ACC_BITS-1:0] eacc,
                                      output logic [NBITS-1:0] edat);
        longint s = 0;
        longint q;
        for (int i = 0; i < n; i++) s += longint'(av[i]) * longint'(wv[i]);
        eacc = s[ACC_BITS-1:0];
        q = s >>> FRAC;
`ifdef FIFO_MAC_SAT_EN
        if (q > 32767) q = 32767;
        else if (q < -32768) q = -32768;
`endif
        edat = q[NBITS-1:0];
    endfunction

    task automatic load(input int av[$], input int wv[$]);
        foreach (av[i]) aq.push_back(NBITS'(av[i]));
        foreach (wv[i]) wq.push_back(NBITS'(wv[i]));
    endtask

    task automatic clear_fifos();
        aq.delete();
        wq.delete();
    endtask

    // Leaves the bench at the negedge after the start edge; t0 is that edge's cyc value.
    task automatic do_start(input int n, output int t0);
        @(negedge clk);
        start = 1'b1;
        len   = LEN_W'(n);
        t0    = cyc + 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_valid(input int budget, output bit ok);
        int k = 0;
        while (out_valid !== 1'b1 && k < budget) begin
            @(negedge clk);
            k++;
        end
        ok = (out_valid === 1'b1);
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; len = '0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({busy, out_valid} !== 2'b00) begin
            tests_failed++; $display("FAIL reset_status: busy/valid=%b expected 00", {busy, out_valid});
        end
        tests_run++;
        if ({a_ren, w_ren} !== 2'b00) begin
            tests_failed++; $display("FAIL reset_ren: ren=%b expected 00", {a_ren, w_ren});
        end
        tests_run++;
        if (out_acc !== '0 || out_data !== '0) begin
            tests_failed++; $display("FAIL reset_data: acc=%0d data=%0d expected 0", out_acc, out_data);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_nominal();
        int av[$] = '{256, 256, 256};
        int wv[$] = '{512, 512, 512};
        logic [ACC_BITS-1:0] eacc; logic [NBITS-1:0] edat;
        int t0, p0; bit ok;
        ref_model(av, wv, 3, eacc, edat);
        load(av, wv);
        out_ready = 1'b1;
        p0 = pop_cnt;
        do_start(3, t0);
        wait_valid(20, ok);
        tests_run++;
        if (!ok || cyc - t0 != 3) begin
            tests_failed++; $display("FAIL nominal_latency: valid=%b edges=%0d expected 3", ok, cyc - t0);
        end
        tests_run++;
        if (out_acc !== eacc || out_data !== edat) begin
            tests_failed++; $display("FAIL nominal_result: acc=%0d data=%0d expected %0d %0d", out_acc, out_data, eacc, edat);
        end
        tests_run++;
        if (pop_cnt - p0 != 3) begin
            tests_failed++; $display("FAIL nominal_pops: %0d expected 3", pop_cnt - p0);
        end
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            tests_failed++; $display("FAIL nominal_idle: busy=%b valid=%b expected 0 0", busy, out_valid);
        end
        clear_fifos();
    endtask

    task automatic test_starvation();
        int av[$] = '{256, 256, 256};
        int wv[$] = '{512, 512, 512};
        logic [ACC_BITS-1:0] eacc; logic [NBITS-1:0] edat;
        int t0, p0, p_stall; bit ok;
        ref_model(av, wv, 3, eacc, edat);
        load(av, wv);
        p0 = pop_cnt;
        do_start(3, t0);
        @(negedge clk);               // first pop on edge t0+1
        w_block = 1'b1;               // weight FIFO looks empty for edges t0+2..t0+4
        p_stall = pop_cnt;
        repeat (3) @(negedge clk);
        tests_run++;
        if (p_stall - p0 != 1 || pop_cnt != p_stall) begin
            tests_failed++; $display("FAIL starve_no_pop: before=%0d during=%0d expected 1 0", p_stall - p0, pop_cnt - p_stall);
        end
        w_block = 1'b0;
        wait_valid(20, ok);
        tests_run++;
        if (!ok || cyc - t0 != 6) begin
            tests_failed++; $display("FAIL starve_latency: valid=%b edges=%0d expected 6", ok, cyc - t0);
        end
        tests_run++;
        if (out_acc !== eacc || out_data !== edat) begin
            tests_failed++; $display("FAIL starve_result: acc=%0d data=%0d expected %0d %0d", out_acc, out_data, eacc, edat);
        end
        @(negedge clk);
        clear_fifos();
    endtask

    task automatic test_overflow();
        int av[$] = '{32767, 32767, 32767, 32767};
        int wv[$] = '{32767, 32767, 32767, 32767};
        logic [ACC_BITS-1:0] eacc; logic [NBITS-1:0] edat;
        int t0; bit ok;
        ref_model(av, wv, 4, eacc, edat);
        load(av, wv);
        do_start(4, t0);
        wait_valid(20, ok);
        tests_run++;
        if (!ok || out_acc !== eacc) begin
            tests_failed++; $display("FAIL overflow_acc: valid=%b acc=%0d expected %0d", ok, out_acc, eacc);
        end
        tests_run++;
        if (out_data !== edat) begin
            tests_failed++; $display("FAIL overflow_data: data=%h expected %h", out_data, edat);
        end
        @(negedge clk);
        clear_fifos();
    endtask

    task automatic test_backpressure();
        int av[$] = '{256, 256, 256, 7, 7, 7};
        int wv[$] = '{512, 512, 512, 9, 9, 9};
        logic [ACC_BITS-1:0] eacc; logic [NBITS-1:0] edat;
        int t0, p0; bit ok;
        ref_model(av, wv, 3, eacc, edat);
        load(av, wv);
        out_ready = 1'b0;
        p0 = pop_cnt;
        do_start(3, t0);
        wait_valid(20, ok);
        tests_run++;
        if (!ok) begin
            tests_failed++; $display("FAIL bp_valid: out_valid=%b expected 1", out_valid);
        end
        for (int i = 0; i < 5; i++) begin
            start = 1'b1; len = LEN_W'(3);
            @(negedge clk);
            tests_run++;
            if (out_valid !== 1'b1 || out_acc !== eacc || out_data !== edat || pop_cnt - p0 != 3) begin
                tests_failed++;
                $display("FAIL bp_hold_%0d: valid=%b acc=%0d data=%0d pops=%0d expected 1 %0d %0d 3",
                         i, out_valid, out_acc, out_data, pop_cnt - p0, eacc, edat);
            end
        end
        start = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || pop_cnt - p0 != 3) begin
            tests_failed++; $display("FAIL bp_idle: busy=%b valid=%b pops=%0d expected 0 0 3", busy, out_valid, pop_cnt - p0);
        end
        clear_fifos();
    endtask

    task automatic test_zero_len();
        int av[$] = '{100};
        int wv[$] = '{200};
        int t0, p0;
        load(av, wv);
        out_ready = 1'b1;
        p0 = pop_cnt;
        do_start(0, t0);
        tests_run++;
        if (out_valid !== 1'b1 || cyc - t0 != 0) begin
            tests_failed++; $display("FAIL zero_latency: valid=%b edges=%0d expected 1 0", out_valid, cyc - t0);
        end
        tests_run++;
        if (out_acc !== '0 || out_data !== '0) begin
            tests_failed++; $display("FAIL zero_result: acc=%0d data=%0d expected 0 0", out_acc, out_data);
        end
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b0 || pop_cnt != p0) begin
            tests_failed++; $display("FAIL zero_nopop: busy=%b pops=%0d expected 0 0", busy, pop_cnt - p0);
        end
        clear_fifos();
    endtask

    task automatic test_reset_midrun();
        int av[$] = '{5, 6, 7, 8};
        int wv[$] = '{9, 10, 11, 12};
        int av2[$] = '{1, 2};
        int wv2[$] = '{3, 4};
        logic [ACC_BITS-1:0] eacc; logic [NBITS-1:0] edat;
        int t0, p0; bit ok;
        load(av, wv);
        p0 = pop_cnt;
        do_start(4, t0);
        repeat (2) @(negedge clk);    // pops on edges t0+1 and t0+2
        #2 rst = 1'b0;
        #1;
        tests_run++;
        if ({busy, out_valid, a_ren, w_ren} !== 4'b0000 || pop_cnt - p0 != 2) begin
            tests_failed++; $display("FAIL midrun_async: busy/valid/aren/wren=%b pops=%0d expected 0000 2",
                                     {busy, out_valid, a_ren, w_ren}, pop_cnt - p0);
        end
        tests_run++;
        if (out_acc !== '0) begin
            tests_failed++; $display("FAIL midrun_acc_clear: acc=%0d expected 0", out_acc);
        end
        clear_fifos();
        @(negedge clk);
        rst = 1'b1;
        ref_model(av2, wv2, 2, eacc, edat);
        load(av2, wv2);
        do_start(2, t0);
        wait_valid(20, ok);
        tests_run++;
        if (!ok || cyc - t0 != 2 || out_acc !== eacc || out_data !== edat) begin
            tests_failed++; $display("FAIL midrun_restart: valid=%b edges=%0d acc=%0d data=%0d expected 1 2 %0d %0d",
                                     ok, cyc - t0, out_acc, out_data, eacc, edat);
        end
        @(negedge clk);
        clear_fifos();
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            int av[$]; int wv[$];
            int n, extra, t0, p0, d;
            logic [NBITS-1:0] r;
            logic [ACC_BITS-1:0] eacc; logic [NBITS-1:0] edat;
            bit ok;
            n     = $urandom_range(1, MAX_LEN);
            extra = $urandom_range(0, 3);
            for (int i = 0; i < n + extra; i++) begin
                r = NBITS'($urandom); av.push_back(int'($signed(r)));
                r = NBITS'($urandom); wv.push_back(int'($signed(r)));
            end
            ref_model(av, wv, n, eacc, edat);
            load(av, wv);
            out_ready = 1'b0;
            rnd_stall = 1'b1;
            p0 = pop_cnt;
            do_start(n, t0);
            wait_valid(n * 10 + 50, ok);
            tests_run++;
            if (!ok || cyc - t0 < n) begin
                tests_failed++; $display("FAIL rand%0d_latency: valid=%b edges=%0d min %0d", it, ok, cyc - t0, n);
            end
            tests_run++;
            if (out_acc !== eacc || out_data !== edat) begin
                tests_failed++; $display("FAIL rand%0d_result: acc=%0d data=%0d expected %0d %0d",
                                         it, out_acc, out_data, eacc, edat);
            end
            tests_run++;
            if (pop_cnt - p0 != n) begin
                tests_failed++; $display("FAIL rand%0d_pops: %0d expected %0d", it, pop_cnt - p0, n);
            end
            d = $urandom_range(0, 3);
            repeat (d) @(negedge clk);
            tests_run++;
            if (out_valid !== 1'b1 || out_acc !== eacc || out_data !== edat) begin
                tests_failed++; $display("FAIL rand%0d_hold: valid=%b acc=%0d data=%0d", it, out_valid, out_acc, out_data);
            end
            out_ready = 1'b1;
            @(negedge clk);
            tests_run++;
            if (busy !== 1'b0) begin
                tests_failed++; $display("FAIL rand%0d_idle: busy=%b expected 0", it, busy);
            end
            rnd_stall = 1'b0;
            a_block   = 1'b0;
            w_block   = 1'b0;
            clear_fifos();
        end
    endtask

    task automatic test_integrity();
        tests_run++;
        if (ren_mismatch != 0 || underflow != 0) begin
            tests_failed++; $display("FAIL ren_integrity: mismatches=%0d underflows=%0d expected 0 0", ren_mismatch, underflow);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_starvation();
        test_overflow();
        test_backpressure();
        test_zero_len();
        test_reset_midrun();
        test_random();
        test_integrity();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_fifo_mac_drain
